// File: rtl/sudoku_pkg.sv
// Shared types and size helpers for the parametrised sudoku game core.
package sudoku_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CHECK, SOLVED} state_t;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_A     = 1;
  localparam int unsigned BTN_B     = 2;
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 4;
  localparam int unsigned BTN_LEFT  = 5;
  localparam int unsigned BTN_RIGHT = 6;
  localparam int unsigned NUM_BTN   = 7;

  function automatic int unsigned calc_n(input int unsigned box);
    return box * box;
  endfunction

  function automatic int unsigned calc_val_w(input int unsigned box);
    return $clog2(box * box + 1);
  endfunction

  function automatic int unsigned calc_cell_w(input int unsigned box);
    return calc_val_w(box) + 1;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned box);
    return $clog2(box * box);
  endfunction

  function automatic int unsigned given_bit(input int unsigned box);
    return calc_val_w(box);
  endfunction

  // Group g: 0..N-1 rows, N..2N-1 columns, 2N..3N-1 boxes; k walks the group's cells.
  function automatic int unsigned group_cell(input int unsigned box, input int unsigned g,
                                             input int unsigned k);
    int unsigned n;
    int unsigned b;
    n = box * box;
    if (g < n) begin
      return g * n + k;
    end else if (g < 2 * n) begin
      return k * n + (g - n);
    end else begin
      b = g - 2 * n;
      return ((b / box) * box + k / box) * n + (b % box) * box + (k % box);
    end
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button to one-cycle press pulse: 2-FF sync, level debounce, rising-edge detect.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             hit;

  assign hit = (sync_q[1] != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= hit && sync_q[1];
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (hit) begin
        cnt_q    <= '0;
        stable_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sudoku_grid_engine.sv
// N x N sudoku game core: buttons, puzzle load, cursor, protected edits, row/col/box scan.
// Optional SUDOKU_MISTAKE_CNT_EN adds a saturating count of a-edits that end in error.
module sudoku_grid_engine
  import sudoku_pkg::*;
#(
  parameter  int unsigned BOX          = 3,
  parameter  int unsigned DEBOUNCE_CYC = 1_000_000,
  localparam int unsigned N            = calc_n(BOX),
  localparam int unsigned VAL_W        = calc_val_w(BOX),
  localparam int unsigned CELL_W       = calc_cell_w(BOX),
  localparam int unsigned IDX_W        = calc_idx_w(BOX),
  localparam int unsigned CELLS        = N * N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    up_button,
  input  logic                    down_button,
  input  logic                    left_button,
  input  logic                    right_button,
  input  logic                    start_button,
  input  logic                    a_button,
  input  logic                    b_button,
  input  logic [CELLS*CELL_W-1:0] initial_board,
  output logic [CELLS*CELL_W-1:0] board,
  output logic [IDX_W-1:0]        cursor_x,
  output logic [IDX_W-1:0]        cursor_y,
  output logic                    error,
  output logic                    solved,
`ifdef SUDOKU_MISTAKE_CNT_EN
  output logic [7:0]              mistakes,
`endif
  output logic                    busy
);

  localparam int unsigned CIDX_W = $clog2(CELLS);
  localparam int unsigned GROUPS = 3 * N;
  localparam int unsigned GRP_W  = $clog2(GROUPS);
  localparam int unsigned GIVEN  = given_bit(BOX);

  state_t              state_q, state_d;
  logic [CELL_W-1:0]   cells_q [CELLS];
  logic [CELL_W-1:0]   cells_d [CELLS];
  logic [CELL_W-1:0]   init_cells [CELLS];
  logic [IDX_W-1:0]    cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic                error_q, error_d, solved_q, solved_d, busy_q, busy_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic                dup_q, dup_d, zero_q, zero_d;

  logic [NUM_BTN-1:0]  raw, pulse;
  logic [CIDX_W-1:0]   cur_idx;
  logic [VAL_W-1:0]    cur_val, inc_val, cv;
  logic                cur_given;
  logic [N-1:0]        mask;
  logic                grp_dup, grp_zero;

  assign raw = {right_button, left_button, down_button, up_button, b_button, a_button, start_button};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
      .clk    (clk),
      .rst_n  (reset),
      .btn_i  (raw[i]),
      .pulse_o(pulse[i])
    );
  end

  for (genvar i = 0; i < CELLS; i++) begin : g_pack
    assign init_cells[i]              = initial_board[i*CELL_W +: CELL_W];
    assign board[i*CELL_W +: CELL_W]  = cells_q[i];
  end

  assign cur_idx   = CIDX_W'(32'(cursor_y_q) * N + 32'(cursor_x_q));
  assign cur_val   = cells_q[cur_idx][VAL_W-1:0];
  assign cur_given = cells_q[cur_idx][GIVEN];
  assign inc_val   = (cur_val >= VAL_W'(N)) ? VAL_W'(0) : cur_val + VAL_W'(1);

  // Occupancy mask over the group selected by grp_q; out-of-range values count as duplicates.
  always_comb begin : scan
    mask     = '0;
    grp_dup  = 1'b0;
    grp_zero = 1'b0;
    cv       = '0;
    for (int k = 0; k < N; k++) begin
      cv = cells_q[CIDX_W'(group_cell(BOX, 32'(grp_q), k))][VAL_W-1:0];
      if (cv == VAL_W'(0)) begin
        grp_zero = 1'b1;
      end else begin
        if (cv > VAL_W'(N) || (mask & (N'(1) << (cv - VAL_W'(1)))) != '0) grp_dup = 1'b1;
        mask = mask | (N'(1) << (cv - VAL_W'(1)));
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    cells_d    = cells_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    error_d    = error_q;
    solved_d   = solved_q;
    grp_d      = '0;
    dup_d      = 1'b0;
    zero_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse[BTN_START]) state_d = LOAD;
      end
      LOAD: begin
        cells_d    = init_cells;
        cursor_x_d = '0;
        cursor_y_d = '0;
        state_d    = CHECK;
      end
      PLAY: begin
        if (pulse[BTN_START]) begin
          state_d = LOAD;
        end else if (pulse[BTN_A]) begin
          if (!cur_given) begin
            cells_d[cur_idx] = {1'b0, inc_val};
            state_d          = CHECK;
          end
        end else if (pulse[BTN_B]) begin
          if (!cur_given) begin
            cells_d[cur_idx] = CELL_W'(0);
            state_d          = CHECK;
          end
        end else if (pulse[BTN_UP]) begin
          cursor_y_d = (cursor_y_q == '0) ? IDX_W'(N - 1) : cursor_y_q - IDX_W'(1);
        end else if (pulse[BTN_DOWN]) begin
          cursor_y_d = (cursor_y_q == IDX_W'(N - 1)) ? '0 : cursor_y_q + IDX_W'(1);
        end else if (pulse[BTN_LEFT]) begin
          cursor_x_d = (cursor_x_q == '0) ? IDX_W'(N - 1) : cursor_x_q - IDX_W'(1);
        end else if (pulse[BTN_RIGHT]) begin
          cursor_x_d = (cursor_x_q == IDX_W'(N - 1)) ? '0 : cursor_x_q + IDX_W'(1);
        end
      end
      CHECK: begin
        dup_d  = dup_q || grp_dup;
        zero_d = zero_q || grp_zero;
        grp_d  = grp_q + GRP_W'(1);
        if (grp_q == GRP_W'(GROUPS - 1)) begin
          error_d  = dup_d;
          solved_d = !dup_d && !zero_d;
          state_d  = solved_d ? SOLVED : PLAY;
          grp_d    = '0;
        end
      end
      SOLVED: begin
        if (pulse[BTN_START]) begin
          state_d  = LOAD;
          solved_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cells_q    <= '{default: '0};
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      error_q    <= 1'b0;
      solved_q   <= 1'b0;
      busy_q     <= 1'b0;
      grp_q      <= '0;
      dup_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cells_q    <= cells_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      error_q    <= error_d;
      solved_q   <= solved_d;
      busy_q     <= busy_d;
      grp_q      <= grp_d;
      dup_q      <= dup_d;
      zero_q     <= zero_d;
    end
  end

`ifdef SUDOKU_MISTAKE_CNT_EN
  logic       from_a_q;
  logic [7:0] mist_q;

  // Remember whether the running scan was started by an a-edit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      from_a_q <= 1'b0;
      mist_q   <= '0;
    end else begin
      if (state_q == PLAY && state_d == CHECK) from_a_q <= pulse[BTN_A];
      if (state_q == LOAD) begin
        mist_q <= '0;
      end else if (state_q == CHECK && state_d != CHECK && from_a_q && error_d &&
                   mist_q != 8'hFF) begin
        mist_q <= mist_q + 8'd1;
      end
    end
  end

  assign mistakes = mist_q;
`endif

  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;
  assign error    = error_q;
  assign solved   = solved_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sudoku_grid_engine.sv
// Randomised bench for sudoku_grid_engine (BOX=3, DEBOUNCE_CYC=4) against a press-level model.
module tb_sudoku_grid_engine;

  localparam int BOX = 3;
  localparam int N   = 9;
  localparam int CW  = 5;
  localparam int NC  = 81;
  localparam int BW  = NC * CW;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    btn;
  logic [BW-1:0] init_board;
  logic [BW-1:0] board;
  logic [3:0]    cx, cy;
  logic          error, solved, busy;
`ifdef SUDOKU_MISTAKE_CNT_EN
  logic [7:0]    mistakes;
`endif

  sudoku_grid_engine #(.BOX(BOX), .DEBOUNCE_CYC(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .up_button    (btn[3]),
    .down_button  (btn[4]),
    .left_button  (btn[5]),
    .right_button (btn[6]),
    .start_button (btn[0]),
    .a_button     (btn[1]),
    .b_button     (btn[2]),
    .initial_board(init_board),
    .board        (board),
    .cursor_x     (cx),
    .cursor_y     (cy),
    .error        (error),
    .solved       (solved),
`ifdef SUDOKU_MISTAKE_CNT_EN
    .mistakes     (mistakes),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  logic [BW-1:0] snap;

  int mval[NC];
  bit mgiv[NC];
  int mx, my, mst, mmist;
  bit merr, msol;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy === 1'b1) begin
      busy_cnt++;
      if (busy_cnt == 2) snap = board;
    end
  endtask

  function automatic int sol(input int y, input int x, input int off);
    return ((y * 3 + y / 3 + x + off) % 9) + 1;
  endfunction

  function automatic int cell_val(input int idx);
    logic [BW-1:0] b;
    b = board;
    return int'(b[idx*CW +: 4]);
  endfunction

  // Any two distinct cells sharing a row, column or box with the same nonzero value conflict.
  task automatic model_scan();
    bit z;
    z    = 0;
    merr = 0;
    for (int i = 0; i < NC; i++) begin
      if (mval[i] == 0) z = 1;
      else if (mval[i] > 9) merr = 1;
    end
    for (int i = 0; i < NC; i++)
      for (int j = i + 1; j < NC; j++)
        if (mval[i] != 0 && mval[i] == mval[j] &&
            ((i / 9 == j / 9) || (i % 9 == j % 9) ||
             ((i / 27 == j / 27) && ((i % 9) / 3 == (j % 9) / 3))))
          merr = 1;
    msol = !merr && !z;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin mval[i] = 0; mgiv[i] = 0; end
    mx = 0; my = 0; mst = 0; merr = 0; msol = 0; mmist = 0;
  endtask

  task automatic model_apply(input logic [6:0] m);
    int act, ci;
    act = -1;
    for (int i = 6; i >= 0; i--) if (m[i]) act = i;
    ci = my * 9 + mx;
    if (act == 0) begin
      for (int i = 0; i < NC; i++) begin
        mval[i] = int'(init_board[i*CW +: 4]);
        mgiv[i] = init_board[i*CW + 4];
      end
      mx = 0; my = 0; mmist = 0;
      model_scan();
      mst = msol ? 2 : 1;
    end else if (mst == 1) begin
      case (act)
        1, 2: if (!mgiv[ci]) begin
          if (act == 1) mval[ci] = (mval[ci] >= 9) ? 0 : mval[ci] + 1;
          else mval[ci] = 0;
          model_scan();
          if (act == 1 && merr && mmist < 255) mmist++;
          mst = msol ? 2 : 1;
        end
        3: my = (my + 8) % 9;
        4: my = (my + 1) % 9;
        5: mx = (mx + 8) % 9;
        6: mx = (mx + 1) % 9;
        default: ;
      endcase
    end
  endtask

  task automatic press_mask(input logic [6:0] m);
    int g;
    busy_cnt = 0;
    btn = m;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
    g = 0;
    while (busy === 1'b1 && g < 100) begin tick(); g++; end
    if (busy !== 1'b0) check("busy_timeout", 512'(busy), 512'(0));
    repeat (2) tick();
    model_apply(m);
  endtask

  task automatic press(input int b);
    logic [6:0] m;
    m = '0;
    m[b] = 1'b1;
    press_mask(m);
  endtask

  task automatic compare_all(input string tag);
    logic [BW-1:0] exp;
    for (int i = 0; i < NC; i++) exp[i*CW +: CW] = {mgiv[i], 4'(mval[i])};
    check({tag, "_board"}, 512'(board), 512'(exp));
    check({tag, "_cx"}, 512'(cx), 512'(mx));
    check({tag, "_cy"}, 512'(cy), 512'(my));
    check({tag, "_err"}, 512'(error), 512'(merr));
    check({tag, "_sol"}, 512'(solved), 512'(msol));
    check({tag, "_busy"}, 512'(busy), 512'(0));
`ifdef SUDOKU_MISTAKE_CNT_EN
    check({tag, "_mist"}, 512'(mistakes), 512'(mmist));
`endif
  endtask

  task automatic gen_random_board();
    int off, r, v;
    off = $urandom_range(0, 8);
    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 9; x++) begin
        v = sol(y, x, off);
        r = $urandom_range(0, 9);
        if (r < 4) init_board[(y*9+x)*CW +: CW] = {1'b1, 4'(v)};
        else if (r < 7) init_board[(y*9+x)*CW +: CW] = 5'd0;
        else init_board[(y*9+x)*CW +: CW] = {1'b0, 4'(v)};
      end
    if ($urandom_range(0, 3) == 0)
      init_board[$urandom_range(0, NC-1)*CW +: CW] = 5'($urandom_range(1, 31));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, r;
    reset = 1'b0;
    btn = '0;
    init_board = '0;
    repeat (3) @(negedge clk);
    check("rst_board", 512'(board), 512'(0));
    check("rst_cx", 512'(cx), 512'(0));
    check("rst_cy", 512'(cy), 512'(0));
    check("rst_err", 512'(error), 512'(0));
    check("rst_sol", 512'(solved), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    init_board[4:0] = {1'b1, 4'd5};
    press(1);
    compare_all("idle_a");
    press(0);
    check("t1_busy_len", 512'(busy_cnt), 512'(28));
    check("t1_load", 512'(snap), 512'(init_board));
    check("t1_err", 512'(error), 512'(0));
    compare_all("t1");

    press(1);
    check("t3_given_busy", 512'(busy_cnt), 512'(0));
    compare_all("t3_given");

    press(5);
    check("t2_left", 512'(cx), 512'(8));
    press(3);
    check("t2_up", 512'(cy), 512'(8));
    press(6);
    check("t2_right", 512'(cx), 512'(0));
    check("t2_row", 512'(cy), 512'(8));
    compare_all("t2");

    repeat (9) press(1);
    check("t3_val9", 512'(cell_val(72)), 512'(9));
    check("t3_edit_busy", 512'(busy_cnt), 512'(27));
    press(1);
    check("t3_wrap0", 512'(cell_val(72)), 512'(0));
    compare_all("t3");

    press(4);
    press(6);
    repeat (5) press(1);
    check("t4_val5", 512'(cell_val(1)), 512'(5));
    check("t4_err", 512'(error), 512'(1));
    compare_all("t4_dup");
    press(2);
    check("t4_clear", 512'(error), 512'(0));
    compare_all("t4");

    press_mask(7'b0100010);
    check("t6_dual_cx", 512'(cx), 512'(1));
    check("t6_dual_val", 512'(cell_val(1)), 512'(1));
    compare_all("t6_dual");
    btn[2] = 1'b1;
    repeat (2) tick();
    btn = '0;
    repeat (12) tick();
    compare_all("t6_glitch");

    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 9; x++)
        init_board[(y*9+x)*CW +: CW] = {1'b1, 4'(sol(y, x, 0))};
    init_board[80*CW +: CW] = 5'd0;
    press(0);
    press(5);
    press(3);
    repeat (7) press(1);
    check("t5_not_yet", 512'(solved), 512'(0));
    press(1);
    check("t5_solved", 512'(solved), 512'(1));
    check("t5_val8", 512'(cell_val(80)), 512'(8));
    compare_all("t5_solved");
    press(1);
    check("t5_ignored_busy", 512'(busy_cnt), 512'(0));
    compare_all("t5_ignored");
    press(0);
    check("t5_reload_sol", 512'(solved), 512'(0));
    check("t5_reload_board", 512'(board), 512'(init_board));
    compare_all("t5_reload");

    press(5);
    press(3);
    btn[1] = 1'b1;
    g = 0;
    while (busy !== 1'b1 && g < 40) begin tick(); g++; end
    check("midchk_busy", 512'(busy), 512'(1));
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("midrst_board", 512'(board), 512'(0));
    check("midrst_cx", 512'(cx), 512'(0));
    check("midrst_cy", 512'(cy), 512'(0));
    check("midrst_err", 512'(error), 512'(0));
    check("midrst_sol", 512'(solved), 512'(0));
    check("midrst_busy", 512'(busy), 512'(0));
    btn = '0;
    tick();
    reset = 1'b1;
    model_reset();
    repeat (4) tick();

`ifdef SUDOKU_MISTAKE_CNT_EN
    init_board = '0;
    init_board[4:0] = {1'b1, 4'd5};
    init_board[9:5] = {1'b1, 4'd5};
    press(0);
    press(6);
    press(6);
    repeat (256) press(1);
    check("mist_sat", 512'(mistakes), 512'(255));
    compare_all("mist");
`endif

    for (int b = 0; b < 8; b++) begin
      gen_random_board();
      press(0);
      compare_all("rnd_load");
      for (int p = 0; p < 25; p++) begin
        r = $urandom_range(0, 99);
        if (r < 3) press(0);
        else if (r < 33) press(1);
        else if (r < 43) press(2);
        else if (r < 58) press(3);
        else if (r < 73) press(4);
        else if (r < 86) press(5);
        else if (r < 97) press(6);
        else press_mask(7'($urandom_range(1, 127)));
        compare_all("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
